// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - shared op codes, FSM states and helpers for the sequential multiplier
package mul_seq_pkg;

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULXSS = 2'b01;
   localparam logic [1:0] OP_MULXSU = 2'b10;
   localparam logic [1:0] OP_MULXUU = 2'b11;

   localparam int HALF_W = 16;
   localparam int ACC_W  = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      FIX   = 2'd3
   } state_t;

   // Left shift of a partial product by index: LL=0, LH/HL=16, HH=32.
   function automatic logic [5:0] pp_shift(input logic [1:0] idx);
      logic [5:0] sh;
      case (idx)
         2'd0:    sh = 6'd0;
         2'd3:    sh = 6'd32;
         default: sh = 6'd16;
      endcase
      return sh;
   endfunction

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// rtl/mul_seq_ctrl_if.sv - request/response bundle between execute stage and the multiplier
interface mul_seq_ctrl_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src1;
   logic [31:0] src2;
   logic        busy;
   logic        done;
   logic [31:0] result_lo;
   logic [31:0] result_hi;

   modport master (
      output start, op, src1, src2,
      input  busy, done, result_lo, result_hi
   );

   modport slave (
      input  start, op, src1, src2,
      output busy, done, result_lo, result_hi
   );
endinterface

// File: rtl/mul16_cell.sv
// rtl/mul16_cell.sv - registered 16x16 unsigned multiplier cell
module mul16_cell
   import mul_seq_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic [HALF_W-1:0]     a,
   input  logic [HALF_W-1:0]     b,
   output logic [2*HALF_W-1:0]   p
);

   // Product register: loads only on enabled edges so it holds for the accumulator.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p <= '0;
      end else if (en) begin
         p <= a * b;
      end
   end

endmodule

// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - 32x32 multiplier sequenced over one 16x16 cell
module mul_seq_ctrl
   import mul_seq_pkg::*;
#(
   parameter bit SKIP_HH_ON_MUL = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   mul_seq_ctrl_if.slave bus
);

   state_t             state, next_state;
   logic [31:0]        mag_a, mag_b;
   logic               neg_flag;
   logic [1:0]         op_q;
   logic [1:0]         idx;
   logic [ACC_W-1:0]   acc;
   logic [ACC_W-1:0]   fix_val;
   logic [31:0]        res_lo, res_hi;
   logic               done_q;
   logic [31:0]        cell_p;
   logic [15:0]        cell_a, cell_b;
   logic               mul_en, acc_en, capture, fix_en;
   logic [1:0]         acc_idx;
   logic [1:0]         last_idx;
   logic               a_neg, b_neg;

   // A is signed for SS/SU, B only for SS; MUL and UU take raw bits.
   assign a_neg = ((bus.op == OP_MULXSS) || (bus.op == OP_MULXSU)) && bus.src1[31];
   assign b_neg = (bus.op == OP_MULXSS) && bus.src2[31];

   // With the skip option the MUL low word never needs the HH term.
   assign last_idx = (SKIP_HH_ON_MUL && (op_q == OP_MUL)) ? 2'd2 : 2'd3;

   // idx[1] picks the A half, idx[0] the B half: LL, LH, HL, HH.
   assign cell_a = idx[1] ? mag_a[31:16] : mag_a[15:0];
   assign cell_b = idx[0] ? mag_b[31:16] : mag_b[15:0];

   assign fix_val = neg_flag ? (~acc + 64'd1) : acc;

   mul16_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .en    (mul_en),
      .a     (cell_a),
      .b     (cell_b),
      .p     (cell_p)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state and per-state datapath strobes.
   always_comb begin
      next_state = state;
      mul_en     = 1'b0;
      acc_en     = 1'b0;
      capture    = 1'b0;
      fix_en     = 1'b0;
      acc_idx    = 2'd0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               capture    = 1'b1;
               next_state = ISSUE;
            end
         end
         ISSUE: begin
            mul_en  = 1'b1;
            acc_en  = (idx != 2'd0);
            acc_idx = idx - 2'd1;
            if (idx == last_idx) begin
               next_state = DRAIN;
            end
         end
         DRAIN: begin
            acc_en     = 1'b1;
            acc_idx    = idx;
            next_state = FIX;
         end
         FIX: begin
            fix_en     = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Operand capture, partial-product accumulation and result write-back.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mag_a    <= '0;
         mag_b    <= '0;
         neg_flag <= 1'b0;
         op_q     <= OP_MUL;
         idx      <= 2'd0;
         acc      <= '0;
         res_lo   <= '0;
         res_hi   <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= fix_en;
         if (capture) begin
            mag_a    <= a_neg ? (~bus.src1 + 32'd1) : bus.src1;
            mag_b    <= b_neg ? (~bus.src2 + 32'd1) : bus.src2;
            neg_flag <= a_neg ^ b_neg;
            op_q     <= bus.op;
            idx      <= 2'd0;
            acc      <= '0;
         end
         if (mul_en && (next_state == ISSUE)) begin
            idx <= idx + 2'd1;
         end
         if (acc_en) begin
            acc <= acc + (ACC_W'(cell_p) << pp_shift(acc_idx));
         end
         if (fix_en) begin
            res_lo <= fix_val[31:0];
            res_hi <= (op_q == OP_MUL) ? 32'd0 : fix_val[63:32];
         end
      end
   end

   assign bus.busy      = (state != IDLE);
   assign bus.done      = done_q;
   assign bus.result_lo = res_lo;
   assign bus.result_hi = res_hi;

endmodule
